uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART RX stage, directly upstream of the RX buffer and status/event logic in the UART peripheral. Oversamples the RX line at 16x baud using the status-register clock divider and runtime frame format (5-8 data bits, optional even/odd parity, 1/2 stop bits). Delivers each received character with parity/framing flags as a one-cycle write strobe to the RX FIFO.

Parameters:
OVERSAMPLE, 16, oversampling ticks per bit; fixed power of two; sample point = OVERSAMPLE/2 - 1
SYNC_STAGES, 2, flip-flops in the RX input synchronizer

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
uart_rx_i  in  1  asynchronous serial RX line, idle high
enable_i  in  1  receiver enable (status enable_RX)
clock_divider_i  in  15  oversample tick period minus 1
data_bits_i  in  uart_data_lenght_t  DBIT5..DBIT8
stop_bits_i  in  uart_stop_bits_t  STOP1/STOP2
parity_mode_i  in  uart_parity_mode_t  EVEN/ODD
parity_enable_i  in  1  parity bit present
data_o  out  8  received character, right-aligned, upper bits zero
data_valid_o  out  1  one-cycle strobe, RX FIFO write enable
parity_error_o  out  1  parity mismatch of character in data_o
frame_error_o  out  1  stop bit sampled low for character in data_o
idle_o  out  1  FSM in IDLE

Behaviour:
- Reset: FSM IDLE; data_o=0, data_valid_o=0, parity_error_o=0, frame_error_o=0, idle_o=1; synchronizer flops preset to 1.
- Tick generator: counter 0..clock_divider_i, tick on terminal count then clears; divider 0 = tick every cycle. Counter and oversample count cleared on start detection.
- Start detection: IDLE and enable_i and synced line falls 1->0. Detection latency SYNC_STAGES+1 cycles after uart_rx_i edge. Frame config inputs latched at detection; later changes affect only next frame.
- Bit sampling: each bit spans OVERSAMPLE ticks; sampled on tick with oversample count 7; state advances on count 15.
- FSM: IDLE -> START -> DATA -> PARITY (only if parity latched enabled) -> STOP -> IDLE.
- START: sample 1 = false start, return IDLE with no strobe.
- DATA: LSB first, N = 5 + data_bits; shift right into bit 7; at end data_o = shift >> (8-N).
- PARITY: expected = XOR(data bits) for EVEN, inverted for ODD; mismatch sets parity_error_o.
- STOP: sample 0 sets frame_error_o. STOP2: both stop bits checked, error if either low.
- Completion: on sample point of last stop bit: data_o/flags registered, data_valid_o=1 for exactly one cycle, FSM to IDLE same cycle (half-bit early for back-to-back tolerance). Characters with errors still strobed.
- Outputs data_o/flags hold until next strobe.
- Break (line held low): frame_error reported; no new start until line returns high then falls.
- enable_i low: abort any frame to IDLE next cycle, no strobe, outputs held.
- No backpressure: RX FIFO overflow handled by consumer.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN: defined -> each bit value = majority of samples at oversample counts 6,7,8; decision taken at count 8, completion strobe at count 8 of last stop bit. Undefined -> single sample at count 7 as above.

Decomposition:
- uart_pkg: reuse uart_data_lenght_t, uart_stop_bits_t, uart_parity_mode_t; add receiver FSM enum uart_rx_state_t { IDLE, START, DATA, PARITY, STOP } and localparam UART_OVERSAMPLE = 16.
- Sub-module uart_baud_generator (divider counter, tick out, synchronous clear), shared with the future transmitter.

Test Plan:
- 8N1, divider 0, send 0xA5 -> single data_valid_o pulse, data_o=0xA5, parity_error_o=0, frame_error_o=0.
- 7 bits EVEN parity, send 0x35 with parity bit 1 -> data_o=0x35, parity_error_o=1; resend with parity 0 -> parity_error_o=0.
- 5 bits STOP2, send 0x1F with second stop bit 0 -> data_o=0x1F, frame_error_o=1.
- Divider 0, line low for 4 clocks then high -> no strobe, idle_o=1 after start-bit sample point.
- 8N1, deassert enable_i during data bit 3 -> no strobe, idle_o=1 one cycle later; next full frame 0x3C received correctly.
- Divider 3, back-to-back 8N1 frames 0x00, 0xFF, no idle gap -> two strobes, data_o=0x00 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver and the future transmitter.
// The receiver's optional majority-vote sampling is selected by UART_RX_MAJORITY_VOTE_EN.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    DBIT5,
    DBIT6,
    DBIT7,
    DBIT8
  } uart_data_lenght_t;

  typedef enum logic {
    STOP1,
    STOP2
  } uart_stop_bits_t;

  typedef enum logic {
    EVEN,
    ODD
  } uart_parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Number of data bits in a character for a given frame format.
  function automatic logic [3:0] data_len(input uart_data_lenght_t bits);
    return 4'd5 + {2'b00, bits};
  endfunction

endpackage

// File: rtl/uart_baud_generator.sv
// Oversample tick generator: counts 0..divider_i and pulses tick_o on terminal count.
// A synchronous clear realigns the tick phase to an external event such as a start edge.
module uart_baud_generator #(
  parameter int DIV_W = 15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count;

  // Greater-or-equal keeps the counter from running the full range when the
  // divider is lowered mid-count.
  assign tick_o = (count >= divider_i) && !clear_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clear_i || tick_o) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART RX stage: 16x oversampled serial-to-parallel receiver with runtime frame format.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority vote.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              uart_rx_i,
  input  logic              enable_i,
  input  logic [14:0]       clock_divider_i,
  input  uart_data_lenght_t data_bits_i,
  input  uart_stop_bits_t   stop_bits_i,
  input  uart_parity_mode_t parity_mode_i,
  input  logic              parity_enable_i,
  output logic [7:0]        data_o,
  output logic              data_valid_o,
  output logic              parity_error_o,
  output logic              frame_error_o,
  output logic              idle_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] LAST_CNT = OS_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [OS_W-1:0] VOTE_A_CNT = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [OS_W-1:0] VOTE_B_CNT = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMPLE_CNT = OS_W'(OVERSAMPLE / 2);
`else
  localparam logic [OS_W-1:0] SAMPLE_CNT = OS_W'(OVERSAMPLE / 2 - 1);
`endif

  uart_rx_state_t    state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              rx_sync, rx_prev;
  logic              tick;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic [7:0]        shift_q;
  logic              par_acc, par_err, frm_err;
  uart_data_lenght_t cfg_bits;
  uart_stop_bits_t   cfg_stop;
  uart_parity_mode_t cfg_parity;
  logic              cfg_par_en;
  logic [3:0]        n_bits;
  logic              bit_val, sample_now, bit_end, last_data, last_stop;
  logic              start_det, complete;

  assign rx_sync    = sync_q[SYNC_STAGES-1];
  assign n_bits     = data_len(cfg_bits);
  assign sample_now = tick && (os_cnt == SAMPLE_CNT);
  assign bit_end    = tick && (os_cnt == LAST_CNT);
  assign last_data  = ({1'b0, bit_cnt} == (n_bits - 4'd1));
  assign last_stop  = (stop_cnt == (cfg_stop == STOP2));
  assign idle_o     = (state == IDLE);

  uart_baud_generator #(.DIV_W(15)) u_baud (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (start_det),
    .divider_i (clock_divider_i),
    .tick_o    (tick)
  );

  // Synchronizer presets high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      rx_prev <= rx_sync;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a, vote_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (tick && (os_cnt == VOTE_A_CNT)) vote_a <= rx_sync;
      if (tick && (os_cnt == VOTE_B_CNT)) vote_b <= rx_sync;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_sync) | (vote_b & rx_sync);
`else
  assign bit_val = rx_sync;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    complete   = 1'b0;
    if (!enable_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (rx_prev && !rx_sync) begin
          start_det  = 1'b1;
          state_next = START;
        end
        START: begin
          if (sample_now && bit_val) state_next = IDLE;
          else if (bit_end)          state_next = DATA;
        end
        DATA:   if (bit_end && last_data) state_next = cfg_par_en ? PARITY : STOP;
        PARITY: if (bit_end) state_next = STOP;
        // Finishing at the last stop-bit sample leaves half a bit to catch a back-to-back start.
        STOP: if (sample_now && last_stop) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      os_cnt         <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      shift_q        <= '0;
      par_acc        <= 1'b0;
      par_err        <= 1'b0;
      frm_err        <= 1'b0;
      cfg_bits       <= DBIT8;
      cfg_stop       <= STOP1;
      cfg_parity     <= EVEN;
      cfg_par_en     <= 1'b0;
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      data_valid_o <= complete;
      if (start_det) begin
        os_cnt     <= '0;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        par_acc    <= 1'b0;
        par_err    <= 1'b0;
        frm_err    <= 1'b0;
        cfg_bits   <= data_bits_i;
        cfg_stop   <= stop_bits_i;
        cfg_parity <= parity_mode_i;
        cfg_par_en <= parity_enable_i;
      end else if (state != IDLE) begin
        if (tick) os_cnt <= os_cnt + 1'b1;
        case (state)
          DATA: begin
            if (sample_now) begin
              shift_q <= {bit_val, shift_q[7:1]};
              par_acc <= par_acc ^ bit_val;
            end
            if (bit_end) bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: if (sample_now) par_err <= bit_val ^ par_acc ^ (cfg_parity == ODD);
          STOP: begin
            if (sample_now && !bit_val) frm_err <= 1'b1;
            if (bit_end) stop_cnt <= 1'b1;
          end
          default: ;
        endcase
      end
      if (complete) begin
        data_o         <= shift_q >> (4'd8 - n_bits);
        parity_error_o <= par_err;
        frame_error_o  <= frm_err | ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: frame formats, errors, false start,
// enable abort and back-to-back frames with hand-computed expectations.
module tb_uart_receiver;
  import uart_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              uart_rx_i = 1'b1;
  logic              enable_i = 1'b0;
  logic [14:0]       clock_divider_i = '0;
  uart_data_lenght_t data_bits_i = DBIT8;
  uart_stop_bits_t   stop_bits_i = STOP1;
  uart_parity_mode_t parity_mode_i = EVEN;
  logic              parity_enable_i = 1'b0;
  logic [7:0]        data_o;
  logic              data_valid_o;
  logic              parity_error_o;
  logic              frame_error_o;
  logic              idle_o;

  int tests_run = 0;
  int tests_failed = 0;

  int         strobes = 0;
  logic [7:0] got_data [0:15];
  logic       got_perr [0:15];
  logic       got_ferr [0:15];

  uart_receiver dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .uart_rx_i       (uart_rx_i),
    .enable_i        (enable_i),
    .clock_divider_i (clock_divider_i),
    .data_bits_i     (data_bits_i),
    .stop_bits_i     (stop_bits_i),
    .parity_mode_i   (parity_mode_i),
    .parity_enable_i (parity_enable_i),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .idle_o          (idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Records every strobe so pulse count and per-character contents can be checked.
  always @(negedge clk_i) begin
    if (data_valid_o === 1'b1) begin
      if (strobes < 16) begin
        got_data[strobes] = data_o;
        got_perr[strobes] = parity_error_o;
        got_ferr[strobes] = frame_error_o;
      end
      strobes++;
    end
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b, input int nclk);
    uart_rx_i = b;
    repeat (nclk) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic two_stop, input logic stop_b,
                            input int per);
    send_bit(1'b0, per);
    for (int i = 0; i < nbits; i++) send_bit(d[i], per);
    if (par_en) send_bit(par_bit, per);
    send_bit(1'b1, per);
    if (two_stop) send_bit(stop_b, per);
    uart_rx_i = 1'b1;
  endtask

  initial begin
    logic [7:0] abort_byte;
    abort_byte = 8'h5A;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_data", 16'(data_o), 16'h0000);
    check("rst_valid", 16'(data_valid_o), 16'h0000);
    check("rst_perr", 16'(parity_error_o), 16'h0000);
    check("rst_ferr", 16'(frame_error_o), 16'h0000);
    check("rst_idle", 16'(idle_o), 16'h0001);
    rst_n_i  = 1'b1;
    enable_i = 1'b1;
    repeat (8) @(negedge clk_i);

    // 8N1, divider 0, 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    repeat (32) @(negedge clk_i);
    check("a5_strobes", 16'(strobes), 16'd1);
    check("a5_data", 16'(got_data[0]), 16'h00A5);
    check("a5_perr", 16'(got_perr[0]), 16'h0000);
    check("a5_ferr", 16'(got_ferr[0]), 16'h0000);
    check("a5_idle", 16'(idle_o), 16'h0001);
    check("a5_hold", 16'(data_o), 16'h00A5);

    // 7E1: 0x35 has four ones, so even parity expects 0
    data_bits_i     = DBIT7;
    parity_enable_i = 1'b1;
    parity_mode_i   = EVEN;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, 16);
    repeat (32) @(negedge clk_i);
    check("p1_strobes", 16'(strobes), 16'd2);
    check("p1_data", 16'(got_data[1]), 16'h0035);
    check("p1_perr", 16'(got_perr[1]), 16'h0001);
    check("p1_ferr", 16'(got_ferr[1]), 16'h0000);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, 16);
    repeat (32) @(negedge clk_i);
    check("p0_strobes", 16'(strobes), 16'd3);
    check("p0_data", 16'(got_data[2]), 16'h0035);
    check("p0_perr", 16'(got_perr[2]), 16'h0000);

    // 5 data bits, two stop bits, second stop low
    data_bits_i     = DBIT5;
    parity_enable_i = 1'b0;
    stop_bits_i     = STOP2;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 16);
    repeat (32) @(negedge clk_i);
    check("s2_strobes", 16'(strobes), 16'd4);
    check("s2_data", 16'(got_data[3]), 16'h001F);
    check("s2_ferr", 16'(got_ferr[3]), 16'h0001);
    check("s2_perr", 16'(got_perr[3]), 16'h0000);

    // False start: line low 4 clocks
    data_bits_i = DBIT8;
    stop_bits_i = STOP1;
    uart_rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("fs_busy", 16'(idle_o), 16'h0000);
    uart_rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("fs_idle", 16'(idle_o), 16'h0001);
    check("fs_strobes", 16'(strobes), 16'd4);
    check("fs_hold", 16'(data_o), 16'h001F);

    // Enable dropped mid data bit 3
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(abort_byte[i], 16);
    send_bit(abort_byte[3], 8);
    check("ab_busy", 16'(idle_o), 16'h0000);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("ab_idle", 16'(idle_o), 16'h0001);
    repeat (7) @(negedge clk_i);
    for (int i = 4; i < 8; i++) send_bit(abort_byte[i], 16);
    send_bit(1'b1, 32);
    enable_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("ab_strobes", 16'(strobes), 16'd4);
    check("ab_hold", 16'(data_o), 16'h001F);
    check("ab_ferr_hold", 16'(frame_error_o), 16'h0001);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    repeat (32) @(negedge clk_i);
    check("3c_strobes", 16'(strobes), 16'd5);
    check("3c_data", 16'(got_data[4]), 16'h003C);
    check("3c_ferr", 16'(got_ferr[4]), 16'h0000);
    check("3c_perr", 16'(got_perr[4]), 16'h0000);

    // Divider 3, back-to-back 0x00 then 0xFF
    clock_divider_i = 15'd3;
    repeat (16) @(negedge clk_i);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 64);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 64);
    repeat (128) @(negedge clk_i);
    check("bb_strobes", 16'(strobes), 16'd7);
    check("bb_data0", 16'(got_data[5]), 16'h0000);
    check("bb_ferr0", 16'(got_ferr[5]), 16'h0000);
    check("bb_perr0", 16'(got_perr[5]), 16'h0000);
    check("bb_data1", 16'(got_data[6]), 16'h00FF);
    check("bb_ferr1", 16'(got_ferr[6]), 16'h0000);
    check("bb_perr1", 16'(got_perr[6]), 16'h0000);
    check("bb_idle", 16'(idle_o), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
